// File: rtl/arb_pkt_mux.sv
// Packet-locking front end for a matrix arbiter: requests arbitration,
// locks the granted channel for a whole packet and forwards its beats.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/data/last   per-channel packet beats (channel i at [i*DW +: DW])
//   in_ready             per-channel ready, at most one bit high
//   req, gnt, upd        arbiter request, one-hot grant, priority update
//   out_valid/data/last  registered downstream beat, out_ready backpressure
//   err                  sticky flag for an illegal grant seen in IDLE
module arb_pkt_mux #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    req,
    input  logic [N-1:0]    gnt,
    output logic            upd,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            err
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sel_q, sel_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mux_data;
    logic            mux_last;
    logic            gnt_onehot;
    logic            hs;

    // sel is one-hot, so a priority-free loop acts as a plain mux
    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_q[i]) begin
                mux_data = in_data[i*DW +: DW];
                mux_last = in_last[i];
            end
        end
    end

    assign gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
    assign hs         = |(in_valid & in_ready);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        err_d    = err_q;
        req      = '0;
        in_ready = '0;
        upd      = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    req = in_valid;
                    if (gnt != '0) begin
                        // a one-hot grant on a valid channel is the only legal win
                        if (gnt_onehot && ((gnt & in_valid) != '0)) begin
                            state_d = LOCK;
                            sel_d   = gnt;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                LOCK: begin
                    // holding req on sel keeps the arbiter grant parked here
                    req = sel_q;
                    if (!out_valid_q || out_ready) begin
                        in_ready = sel_q;
                    end
                    if (|(in_valid & sel_q) && (!out_valid_q || out_ready)
                        && mux_last) begin
                        upd     = 1'b1;
                        state_d = IDLE;
                        sel_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (hs) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_last_d  = mux_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Directed bench for arb_pkt_mux with a rotating-priority arbiter model
// (initial order 0>1>2, winner drops to lowest priority on upd).
module tb_arb_pkt_mux;

    logic        clk;
    logic        rst;
    logic [2:0]  in_valid;
    logic [23:0] in_data;
    logic [2:0]  in_last;
    logic [2:0]  in_ready;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic        upd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        err;

    logic        frc;
    logic [2:0]  frc_val;
    logic [2:0]  gnt_arb;
    int          ptr;
    int          n_assert;
    int          n_fail;

    arb_pkt_mux #(.N(3), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .upd       (upd),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        gnt_arb = '0;
        for (int o = 0; o < 3; o++) begin
            if (req[(ptr + o) % 3] && gnt_arb == '0)
                gnt_arb[(ptr + o) % 3] = 1'b1;
        end
    end

    assign gnt = frc ? frc_val : gnt_arb;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 0;
        end else if (upd) begin
            for (int i = 0; i < 3; i++)
                if (gnt[i]) ptr <= (i + 1) % 3;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input int ch, input logic [7:0] v);
        in_data[ch*8 +: 8] = v;
    endtask

    task automatic do_reset();
        in_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 3'b111;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        frc       = 1'b0;
        frc_val   = '0;

        // reset behaviour
        #1;
        chk("rst_req", 8'(req), 8'h0);
        chk("rst_rdy", 8'(in_ready), 8'h0);
        chk("rst_upd", 8'(upd), 8'h0);
        tick();
        chk("rst_ov", 8'(out_valid), 8'h0);
        chk("rst_od", out_data, 8'h0);
        chk("rst_ol", 8'(out_last), 8'h0);
        chk("rst_err", 8'(err), 8'h0);
        rst = 1'b0;

        // single-beat packets, all channels valid
        in_valid = 3'b111;
        in_last  = 3'b111;
        setd(0, 8'hA0);
        setd(1, 8'hA1);
        setd(2, 8'hA2);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sb_idle_rdy", 8'(in_ready), 8'h0);
            chk("sb_idle_upd", 8'(upd), 8'h0);
            chk("sb_idle_req", 8'(req), 8'h7);
            if (k > 0) begin
                chk("sb_ov", 8'(out_valid), 8'h1);
                chk("sb_od", out_data, 8'(8'hA0 + k - 1));
            end
            tick();
            #1;
            chk("sb_lk_req", 8'(req), 8'(1 << k));
            chk("sb_lk_rdy", 8'(in_ready), 8'(1 << k));
            chk("sb_lk_upd", 8'(upd), 8'h1);
            tick();
        end
        #1;
        chk("sb_ov_last", 8'(out_valid), 8'h1);
        chk("sb_od_last", out_data, 8'hA2);
        do_reset();

        // multi-beat lock on ch0 while ch2 waits
        in_valid = 3'b101;
        in_last  = 3'b100;
        setd(2, 8'h55);
        setd(0, 8'h10);
        #1;
        chk("mb_idle_req", 8'(req), 8'h5);
        chk("mb_idle_rdy", 8'(in_ready), 8'h0);
        tick();
        for (int b = 0; b < 4; b++) begin
            setd(0, 8'(8'h10 + b));
            in_last[0] = (b == 3);
            #1;
            chk("mb_rdy", 8'(in_ready), 8'h1);
            chk("mb_upd", 8'(upd), 8'(b == 3));
            if (b > 0) begin
                chk("mb_ov", 8'(out_valid), 8'h1);
                chk("mb_od", out_data, 8'(8'h10 + b - 1));
                chk("mb_ol", 8'(out_last), 8'h0);
            end
            tick();
        end
        in_valid = 3'b100;
        #1;
        chk("mb_od13", out_data, 8'h13);
        chk("mb_ol13", 8'(out_last), 8'h1);
        chk("mb_ov13", 8'(out_valid), 8'h1);
        chk("mb_bub_rdy", 8'(in_ready), 8'h0);
        chk("mb_bub_upd", 8'(upd), 8'h0);
        chk("mb_bub_req", 8'(req), 8'h4);
        tick();
        #1;
        chk("mb_c2_rdy", 8'(in_ready), 8'h4);
        chk("mb_c2_upd", 8'(upd), 8'h1);
        chk("mb_c2_ov", 8'(out_valid), 8'h0);
        tick();
        #1;
        chk("mb_c2_od", out_data, 8'h55);
        chk("mb_c2_ol", 8'(out_last), 8'h1);
        do_reset();

        // backpressure mid-packet on ch1
        in_valid = 3'b010;
        in_last  = 3'b000;
        setd(1, 8'h20);
        #1;
        chk("bp_idle_rdy", 8'(in_ready), 8'h0);
        tick();
        #1;
        chk("bp_rdy0", 8'(in_ready), 8'h2);
        tick();
        setd(1, 8'h21);
        #1;
        chk("bp_od20", out_data, 8'h20);
        chk("bp_rdy1", 8'(in_ready), 8'h2);
        tick();
        setd(1, 8'h22);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_hold_od", out_data, 8'h21);
            chk("bp_hold_ov", 8'(out_valid), 8'h1);
            chk("bp_hold_rdy", 8'(in_ready), 8'h0);
            chk("bp_hold_req", 8'(req), 8'h2);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_od", out_data, 8'h21);
        chk("bp_rel_rdy", 8'(in_ready), 8'h2);
        tick();
        setd(1, 8'h23);
        in_last = 3'b010;
        #1;
        chk("bp_od22", out_data, 8'h22);
        chk("bp_upd", 8'(upd), 8'h1);
        tick();
        in_valid = '0;
        #1;
        chk("bp_od23", out_data, 8'h23);
        chk("bp_ol23", 8'(out_last), 8'h1);
        chk("bp_ov23", 8'(out_valid), 8'h1);
        tick();
        #1;
        chk("bp_drain", 8'(out_valid), 8'h0);
        do_reset();

        // illegal grants in IDLE
        in_valid = 3'b011;
        in_last  = 3'b011;
        setd(0, 8'h60);
        frc      = 1'b1;
        frc_val  = 3'b100;
        #1;
        chk("bg_unc_rdy", 8'(in_ready), 8'h0);
        tick();
        #1;
        chk("bg_unc_err", 8'(err), 8'h1);
        chk("bg_unc_rdy2", 8'(in_ready), 8'h0);
        do_reset();
        #1;
        chk("bg_err_clr", 8'(err), 8'h0);
        in_valid = 3'b011;
        frc_val  = 3'b011;
        #1;
        chk("bg_mh_rdy", 8'(in_ready), 8'h0);
        tick();
        #1;
        chk("bg_mh_err", 8'(err), 8'h1);
        chk("bg_mh_rdy2", 8'(in_ready), 8'h0);
        frc = 1'b0;
        tick();
        #1;
        chk("bg_ok_rdy", 8'(in_ready), 8'h1);
        chk("bg_sticky", 8'(err), 8'h1);
        tick();
        #1;
        chk("bg_ok_od", out_data, 8'h60);
        chk("bg_sticky2", 8'(err), 8'h1);
        do_reset();
        #1;
        chk("bg_err_rst", 8'(err), 8'h0);

        // reset in the middle of a ch0 packet
        in_valid = 3'b001;
        in_last  = 3'b000;
        setd(0, 8'h30);
        #1;
        tick();
        #1;
        chk("rm_rdy0", 8'(in_ready), 8'h1);
        tick();
        setd(0, 8'h31);
        #1;
        chk("rm_od30", out_data, 8'h30);
        tick();
        setd(0, 8'h32);
        rst = 1'b1;
        #1;
        chk("rm_rst_req", 8'(req), 8'h0);
        chk("rm_rst_rdy", 8'(in_ready), 8'h0);
        chk("rm_rst_upd", 8'(upd), 8'h0);
        tick();
        rst      = 1'b0;
        in_valid = 3'b010;
        in_last  = 3'b010;
        setd(1, 8'h40);
        #1;
        chk("rm_ov", 8'(out_valid), 8'h0);
        chk("rm_idle_rdy", 8'(in_ready), 8'h0);
        chk("rm_idle_req", 8'(req), 8'h2);
        tick();
        #1;
        chk("rm_new_rdy", 8'(in_ready), 8'h2);
        chk("rm_new_upd", 8'(upd), 8'h1);
        tick();
        #1;
        chk("rm_new_od", out_data, 8'h40);
        chk("rm_new_ol", 8'(out_last), 8'h1);
        do_reset();

        // source stall inside a ch2 packet
        in_valid = 3'b100;
        in_last  = 3'b000;
        setd(2, 8'h50);
        #1;
        tick();
        #1;
        chk("ss_rdy0", 8'(in_ready), 8'h4);
        tick();
        in_valid = '0;
        #1;
        chk("ss_od50", out_data, 8'h50);
        chk("ss_req1", 8'(req), 8'h4);
        tick();
        #1;
        chk("ss_drain", 8'(out_valid), 8'h0);
        chk("ss_req2", 8'(req), 8'h4);
        chk("ss_rdy2", 8'(in_ready), 8'h4);
        chk("ss_upd2", 8'(upd), 8'h0);
        tick();
        in_valid = 3'b100;
        setd(2, 8'h51);
        #1;
        chk("ss_resume", 8'(in_ready), 8'h4);
        tick();
        setd(2, 8'h52);
        in_last = 3'b100;
        #1;
        chk("ss_od51", out_data, 8'h51);
        chk("ss_upd", 8'(upd), 8'h1);
        tick();
        in_valid = '0;
        #1;
        chk("ss_od52", out_data, 8'h52);
        chk("ss_ol52", 8'(out_last), 8'h1);
        chk("ss_req_end", 8'(req), 8'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_pkt_mux.md
ARB_PKT_MUX -- requirements
Module: arb_pkt_mux

Interface
REQ-001 Parameter N, default 3: number of input channels; SHALL equal the N of the matrix arbiter it drives.
REQ-002 Parameter DW, default 8: data width per beat.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  N  per-channel beat valid.
REQ-006 in_data  input  N*DW  per-channel data; channel i occupies bits [i*DW +: DW].
REQ-007 in_last  input  N  per-channel last-beat-of-packet flag.
REQ-008 in_ready  output  N  per-channel ready; at most one bit high in any cycle.
REQ-009 req  output  N  request vector to the arbiter.
REQ-010 gnt  input  N  one-hot grant from the arbiter; combinational in req.
REQ-011 upd  output  1  arbiter priority-update strobe.
REQ-012 out_valid, out_data[DW], out_last  output  downstream beat, registered.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 The FSM SHALL have two states: IDLE and LOCK, with a sel register (N bits, one-hot) naming the locked channel.
REQ-016 IDLE: req SHALL be in_valid, in_ready SHALL be 0, and upd SHALL be 0.
REQ-017 IDLE -> LOCK SHALL occur when gnt is one-hot and gnt & in_valid is nonzero; sel <= gnt.
REQ-018 In IDLE, a gnt that is nonzero and either not one-hot or not covered by in_valid SHALL be ignored (no transition) and SHALL set err.
REQ-019 LOCK: req SHALL equal sel, so the arbiter grant stays on the locked channel; gnt SHALL be ignored.
REQ-020 LOCK: in_ready SHALL be sel when (!out_valid || out_ready), otherwise 0.
REQ-021 An input handshake (in_valid[k] & in_ready[k]) SHALL load out_data/out_last from channel k and set out_valid on the next edge (1-cycle latency).
REQ-022 When out_valid && out_ready and there is no input handshake, out_valid SHALL clear on the next edge; a simultaneous input handshake SHALL reload without a bubble.
REQ-023 upd SHALL be high combinationally in exactly the cycle of the input handshake whose in_last is 1; the FSM SHALL return to IDLE on that edge.
REQ-024 Each packet SHALL incur a one-cycle arbitration bubble (IDLE cycle), so a single-beat packet takes 2 cycles per channel switch.
REQ-025 Beats from different channels SHALL never interleave at out_*; packet beat order SHALL be preserved.
REQ-026 in_valid[sel] dropping during LOCK SHALL stall without releasing the lock.
REQ-027 out_data and out_last SHALL hold when out_valid && !out_ready.

Reset
REQ-028 When rst is high at an edge: state <= IDLE, sel <= 0, out_valid <= 0, out_data <= 0, out_last <= 0, err <= 0.
REQ-029 While rst is high, in_ready and upd SHALL be 0 and req SHALL be 0.
REQ-030 Reset mid-packet SHALL drop the lock and discard the buffered beat; no upd SHALL be issued for the truncated packet.
REQ-031 err SHALL clear only through reset.

Verification
REQ-032 Single-beat packets: N=3, in_valid=3'b111 with in_last=1, out_ready=1, arbiter with priority order 0>1>2 -> channels 0,1,2 are each output once, one beat every 2 cycles, with an upd pulse on each handshake.
REQ-033 Multi-beat lock: ch0 sends a 4-beat packet (0x10..0x13) while ch2 is valid throughout -> out shows 0x10,0x11,0x12,0x13 contiguous with out_last on 0x13, then ch2's data; upd is high once.
REQ-034 Backpressure: out_ready=0 for 3 cycles mid-packet -> in_ready is 0, out_data is held stable, and no beat is lost or duplicated after out_ready returns to 1.
REQ-035 Bad grant: force gnt=3'b011 in IDLE -> no lock and in_ready stays 0, err=1 and remains set until rst.
REQ-036 Reset mid-packet: rst pulses after 2 of 4 beats -> next cycle out_valid=0, state IDLE, no upd; the following packet is arbitrated normally.
REQ-037 Source stall: in_valid[sel] is low for 2 cycles inside a packet -> out_valid drains, the lock is held, and req stays equal to sel.
